// File: rtl/vend_ctrl.sv
// Vending-machine button controller: per-button debounce, one-deep pending capture,
// fixed-priority grant, change dispensing through a nickel hopper, and spaced command pulses.
//
// state    | meaning
// IDLE     | arbitrate pending buttons
// CMD      | one-cycle command pulse for the granted button
// GAP      | GAP_CYC quiet cycles after every pulse
// CHG_REQ  | request one nickel from the hopper, watch for timeout
// CHG_WAIT | one-cycle hop_req low gap between nickels
module vend_ctrl #(
    parameter int DB_CYC  = 4,
    parameter int GAP_CYC = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       nic,
    input  logic       dim,
    input  logic       ch,
    input  logic       obj1,
    input  logic       obj2,
    input  logic [3:0] coin,
    input  logic       hop_ack,
    output logic [4:0] cmd,
    output logic       hop_req,
    output logic       busy,
    output logic       err
);

    typedef enum logic [2:0] {IDLE, CMD, CHG_REQ, CHG_WAIT, GAP} state_t;

    state_t      state, state_nxt;
    logic [4:0]  raw;
    logic [4:0]  db;
    logic [3:0]  db_cnt [5];
    logic [4:0]  db_hit;
    logic [4:0]  rise;
    logic [4:0]  pend;
    logic [4:0]  grant;
    logic [4:0]  sel;
    logic [1:0]  nick_cnt;
    logic [1:0]  coin_n;
    logic        coin_bad;
    logic [2:0]  gap_cnt;
    logic [7:0]  tmo_cnt;
    logic        timeout;

    // bit order matches cmd: {obj2,obj1,dim,nic,ch}, so bit 0 is highest priority
    assign raw   = {obj2, obj1, dim, nic, ch};
    assign grant = (state == IDLE) ? (pend & (~pend + 5'd1)) : 5'd0;
    assign timeout = (state == CHG_REQ) && !hop_ack && (tmo_cnt == 8'd0);

    always_comb begin
        db_hit = '0;
        for (int i = 0; i < 5; i++)
            db_hit[i] = (raw[i] != db[i]) && (db_cnt[i] == 4'(DB_CYC - 1));
        rise = db_hit & raw;
    end

    always_comb begin
        coin_n   = 2'd0;
        coin_bad = 1'b0;
        case (coin)
            4'b1000: coin_n = 2'd0;
            4'b0100: coin_n = 2'd1;
            4'b0010: coin_n = 2'd2;
            4'b0001: coin_n = 2'd3;
            default: coin_bad = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            db <= '0;
            for (int i = 0; i < 5; i++)
                db_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 5; i++) begin
                if (raw[i] == db[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_hit[i]) begin
                    db_cnt[i] <= '0;
                    db[i]     <= ~db[i];
                end else begin
                    db_cnt[i] <= db_cnt[i] + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend     <= '0;
            sel      <= '0;
            nick_cnt <= '0;
            err      <= 1'b0;
            gap_cnt  <= '0;
            tmo_cnt  <= '0;
        end else begin
            pend    <= (pend & ~grant) | rise;
            gap_cnt <= (state == GAP) ? gap_cnt - 3'd1 : 3'(GAP_CYC - 1);
            // reloaded every time CHG_REQ is left, so each nickel gets a fresh 255-cycle window
            tmo_cnt <= (state == CHG_REQ) ? tmo_cnt - 8'd1 : 8'd254;
            if (grant != 5'd0) begin
                sel <= grant;
                if (grant[0]) begin
                    nick_cnt <= coin_n;
                    if (coin_bad)
                        err <= 1'b1;
                end
            end
            if (state == CHG_REQ && hop_ack)
                nick_cnt <= nick_cnt - 2'd1;
            if (timeout) begin
                nick_cnt <= '0;
                err      <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:
                if (grant != 5'd0)
                    state_nxt = (grant[0] && coin_n != 2'd0) ? CHG_REQ : CMD;
            CMD:
                state_nxt = GAP;
            GAP:
                if (gap_cnt == 3'd0)
                    state_nxt = IDLE;
            CHG_REQ:
                if (hop_ack)
                    state_nxt = CHG_WAIT;
                else if (timeout)
                    state_nxt = CMD;
            CHG_WAIT:
                state_nxt = (nick_cnt == 2'd0) ? CMD : CHG_REQ;
            default:
                state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cmd     = (state == CMD) ? sel : 5'd0;
        hop_req = (state == CHG_REQ);
        busy    = (state != IDLE);
    end

endmodule

// File: tb/tb_vend_ctrl.sv
// Self-checking bench for vend_ctrl: expected command pulses are queued at stimulus time
// and popped as the DUT emits them; activity counters back the per-scenario checks.
module tb_vend_ctrl;

    localparam int DB_CYC  = 4;
    localparam int GAP_CYC = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] btn;
    logic [3:0] coin;
    logic       hop_ack;
    logic       hop_en;
    logic [4:0] cmd;
    logic       hop_req;
    logic       busy;
    logic       err;

    int         n_tests = 0;
    int         n_fail  = 0;
    int         cyc     = 0;
    int         busy_cyc, hopreq_cyc, hop_rise;
    logic       hop_req_d = 1'b0;
    logic [4:0] exp_q [$];
    int         pt [$];

    vend_ctrl #(.DB_CYC(DB_CYC), .GAP_CYC(GAP_CYC)) dut (
        .clk     (clk),
        .rst     (rst),
        .nic     (btn[1]),
        .dim     (btn[2]),
        .ch      (btn[0]),
        .obj1    (btn[3]),
        .obj2    (btn[4]),
        .coin    (coin),
        .hop_ack (hop_ack),
        .cmd     (cmd),
        .hop_req (hop_req),
        .busy    (busy),
        .err     (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // hopper answers in the first cycle hop_req is seen high
    always @(negedge clk)
        hop_ack = hop_en & hop_req;

    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            if (busy)    busy_cyc++;
            if (hop_req) hopreq_cyc++;
            if (hop_req && !hop_req_d) hop_rise++;
            if (cmd != 5'd0) begin
                pt.push_back(cyc);
                if (exp_q.size() == 0)
                    chk("cmd_unexp", {27'd0, cmd}, 32'd0);
                else
                    chk("cmd", {27'd0, cmd}, {27'd0, exp_q.pop_front()});
            end
        end
        hop_req_d = hop_req;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clr_stats();
        busy_cyc   = 0;
        hopreq_cyc = 0;
        hop_rise   = 0;
        pt.delete();
    endtask

    task automatic press(input int b, input int n);
        btn[b] = 1'b1;
        tick(n);
        btn[b] = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; btn = '0; coin = 4'b1000; hop_ack = 1'b0; hop_en = 1'b0;
        clr_stats();
        tick(3);
        chk("rst_cmd",  {27'd0, cmd}, 32'd0);
        chk("rst_hreq", {31'd0, hop_req}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_err",  {31'd0, err}, 32'd0);
        rst = 1'b0;
        tick(2);

        // too-short nic press is filtered, full press gives one pulse
        clr_stats();
        press(1, DB_CYC - 1);
        tick(12);
        chk("short_busy", busy_cyc, 0);
        clr_stats();
        exp_q.push_back(5'b00010);
        press(1, DB_CYC + 2);
        tick(12);
        chk("nic_busy",   busy_cyc, 1 + GAP_CYC);
        chk("nic_pulses", pt.size(), 1);
        chk("nic_sb",     exp_q.size(), 0);

        // simultaneous rises served in priority order; pulse starts are CMD+GAP+IDLE apart
        clr_stats();
        exp_q.push_back(5'b00010);
        exp_q.push_back(5'b00100);
        exp_q.push_back(5'b01000);
        btn = 5'b01110;
        tick(DB_CYC + 2);
        btn = '0;
        tick(20);
        chk("multi_pulses", pt.size(), 3);
        if (pt.size() >= 3) begin
            chk("multi_gap01", pt[1] - pt[0], GAP_CYC + 2);
            chk("multi_gap12", pt[2] - pt[1], GAP_CYC + 2);
        end
        chk("multi_sb", exp_q.size(), 0);

        // 15c change: three acked nickels then ch
        coin = 4'b0001; hop_en = 1'b1;
        clr_stats();
        exp_q.push_back(5'b00001);
        press(0, DB_CYC + 2);
        tick(25);
        chk("chg3_rise", hop_rise, 3);
        chk("chg3_hcyc", hopreq_cyc, 3);
        chk("chg3_err",  {31'd0, err}, 32'd0);
        chk("chg3_sb",   exp_q.size(), 0);

        // no change due: ch pulse directly after grant
        coin = 4'b1000;
        clr_stats();
        exp_q.push_back(5'b00001);
        press(0, DB_CYC + 2);
        tick(15);
        chk("chg0_rise", hop_rise, 0);
        chk("chg0_busy", busy_cyc, 1 + GAP_CYC);
        chk("chg0_err",  {31'd0, err}, 32'd0);

        // malformed coin: ch still issued, err raised
        coin = 4'b0110;
        clr_stats();
        exp_q.push_back(5'b00001);
        press(0, DB_CYC + 2);
        tick(15);
        chk("badcoin_rise", hop_rise, 0);
        chk("badcoin_err",  {31'd0, err}, 32'd1);
        chk("badcoin_sb",   exp_q.size(), 0);
        do_reset();
        chk("err_cleared", {31'd0, err}, 32'd0);

        // hopper never answers: 255-cycle timeout
        coin = 4'b0100; hop_en = 1'b0;
        clr_stats();
        exp_q.push_back(5'b00001);
        press(0, DB_CYC + 2);
        tick(280);
        chk("tmo_hcyc", hopreq_cyc, 255);
        chk("tmo_err",  {31'd0, err}, 32'd1);
        chk("tmo_busy", {31'd0, busy}, 32'd0);
        chk("tmo_sb",   exp_q.size(), 0);
        do_reset();

        // reset mid-dispense abandons ch; nic held through reset becomes a fresh press
        coin = 4'b0010;
        clr_stats();
        press(0, DB_CYC + 2);
        for (int i = 0; i < 20 && !hop_req; i++)
            tick(1);
        if (!hop_req)
            chk("wait_hop", 32'd0, 32'd1);
        rst = 1'b1;
        btn[1] = 1'b1;
        tick(1);
        chk("mid_busy", {31'd0, busy}, 32'd0);
        chk("mid_hreq", {31'd0, hop_req}, 32'd0);
        chk("mid_cmd",  {27'd0, cmd}, 32'd0);
        tick(1);
        rst = 1'b0;
        exp_q.push_back(5'b00010);
        tick(DB_CYC + 4);
        btn[1] = 1'b0;
        tick(20);
        chk("mid_pulses", pt.size(), 1);
        chk("mid_err",    {31'd0, err}, 32'd0);

        chk("sb_end", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
